sm_tile_compositor: RTL and testbench

//  Downstream of the GPU controller. Queues draw jobs (background or sprite) and one flush token per tile.

---
 rtl/gpu_pkg.sv | 18 +
 rtl/tile_job_fifo.sv | 57 +++++
 rtl/sm_tile_compositor.sv | 150 +++++++++++++++
 tb/tb_sm_tile_compositor.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types for the tile compositor: job queue entry, FSM states and tile constants.
package gpu_pkg;
    localparam int TILE_DIM = 16;
    localparam logic [7:0] TEX_TRANSPARENT = 8'h00;

    typedef struct packed {
        logic       is_flush;
        logic [7:0] tex;
        logic [7:0] z;
        logic [3:0] start_x;
        logic [5:0] tile_x;
        logic [5:0] tile_y;
    } job_t;

    localparam int JOB_W = $bits(job_t);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_FLUSH} state_t;
endpackage

// File: rtl/tile_job_fifo.sv
// Job queue with two write ports (draw first, flush second) and drop-on-full.
module tile_job_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push_a,
    input  job_t din_a,
    input  logic push_b,
    input  job_t din_b,
    input  logic pop,
    output job_t dout,
    output logic empty,
    output logic full,
    output logic overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [JOB_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, space;
    logic             do_pop, acc_a, acc_b;

    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    always_comb begin
        do_pop = pop && !empty;
        space  = (AW+1)'(DEPTH) - count + (AW+1)'(do_pop);
        acc_a  = push_a && (space != '0);
        acc_b  = push_b && (space > (AW+1)'(acc_a));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(acc_a) + AW'(acc_b);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(acc_a) + (AW+1)'(acc_b) - (AW+1)'(do_pop);
            if ((push_a && !acc_a) || (push_b && !acc_b))
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_a) mem[wr_ptr] <= din_a;
        if (acc_b) mem[wr_ptr + AW'(acc_a)] <= din_b;
    end

    assign dout  = job_t'(mem[rd_ptr]);
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
endmodule

// File: rtl/sm_tile_compositor.sv
// Tile compositor: z-tests queued draw jobs into a 16x16 tile buffer and streams
// the finished tile to the framebuffer writer on each flush token.
module sm_tile_compositor
    import gpu_pkg::*;
#(
    parameter int JOB_FIFO_DEPTH = 8,
    parameter int TEX_LATENCY    = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_calc_ena,
    input  logic [3:0]   i_calc_start_x,
    input  logic [7:0]   i_calc_position_z,
    input  logic [7:0]   i_texture_idx,
    input  logic [5:0]   i_tile_x,
    input  logic [5:0]   i_tile_y,
    input  logic         i_sm_render_done,
    output logic [11:0]  o_tex_addr,
    output logic         o_tex_re,
    input  logic [127:0] i_tex_data,
    output logic         o_fb_valid,
    input  logic         i_fb_ready,
    output logic [8:0]   o_fb_line,
    output logic [5:0]   o_fb_tile_x,
    output logic [127:0] o_fb_data,
    output logic         o_fifo_full,
    output logic         o_overflow,
    output logic         o_busy
);
    localparam logic [4:0] DRAW_LAST = 5'(TILE_DIM - 1 + TEX_LATENCY);

    state_t state, state_nxt;
    job_t   job, head, draw_ent, flush_ent;
    logic   fifo_pop, fifo_empty, done_q, flush_push, fb_acc, merge_en;
    logic [4:0] cnt;
    logic [3:0] mrow;

    logic [TEX_LATENCY:1]       vld_pipe;
    logic [TEX_LATENCY:1][3:0]  row_pipe;

    logic [TILE_DIM-1:0][TILE_DIM-1:0][7:0] color_buf, z_buf;
    logic [TILE_DIM-1:0][7:0] shifted;
    logic [TILE_DIM-1:0]      wr_mask;

    assign flush_push = i_sm_render_done && !done_q;

    always_comb begin
        draw_ent  = '{is_flush: 1'b0, tex: i_texture_idx, z: i_calc_position_z,
                      start_x: i_calc_start_x, tile_x: i_tile_x, tile_y: i_tile_y};
        flush_ent = '{is_flush: 1'b1, tex: 8'h00, z: 8'h00, start_x: 4'h0,
                      tile_x: i_tile_x, tile_y: i_tile_y};
    end

    tile_job_fifo #(.DEPTH(JOB_FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_a   (i_calc_ena),
        .din_a    (draw_ent),
        .push_b   (flush_push),
        .din_b    (flush_ent),
        .pop      (fifo_pop),
        .dout     (head),
        .empty    (fifo_empty),
        .full     (o_fifo_full),
        .overflow (o_overflow)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                state_nxt = head.is_flush ? ST_FLUSH : ST_DRAW;
            end
            ST_DRAW:  if (cnt == DRAW_LAST) state_nxt = ST_IDLE;
            ST_FLUSH: if (fb_acc && cnt[3:0] == 4'hF) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign o_tex_re    = (state == ST_DRAW) && !cnt[4];
    assign o_tex_addr  = o_tex_re ? {job.tex, cnt[3:0]} : 12'h000;
    assign o_fb_valid  = (state == ST_FLUSH) && job.is_flush;
    assign fb_acc      = o_fb_valid && i_fb_ready;
    assign o_fb_line   = o_fb_valid ? {job.tile_y, cnt[3:0]} : 9'h000;
    assign o_fb_tile_x = o_fb_valid ? job.tile_x : 6'h00;
    assign o_fb_data   = o_fb_valid ? color_buf[cnt[3:0]] : 128'h0;
    assign o_busy      = (state != ST_IDLE) || !fifo_empty;

    assign merge_en = vld_pipe[TEX_LATENCY];
    assign mrow     = row_pipe[TEX_LATENCY];

    // Shifting the row left by start_x texels lines texel 0 up with column start_x;
    // vacated columns read as transparent and overshoot texels fall off the top.
    always_comb begin
        shifted = i_tex_data << {i_calc_start_x_unused_guard(job.start_x), 3'b000};
        for (int c = 0; c < TILE_DIM; c++)
            wr_mask[c] = (shifted[c] != TEX_TRANSPARENT) && (job.z >= z_buf[mrow][c]);
    end

    function automatic logic [3:0] i_calc_start_x_unused_guard(input logic [3:0] sx);
        return sx;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            job       <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
            vld_pipe  <= '0;
            row_pipe  <= '0;
            color_buf <= '0;
            z_buf     <= '0;
        end else begin
            done_q <= i_sm_render_done;
            for (int i = TEX_LATENCY; i > 1; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                row_pipe[i] <= row_pipe[i-1];
            end
            vld_pipe[1] <= o_tex_re;
            row_pipe[1] <= cnt[3:0];

            if (fifo_pop) begin
                job <= head;
                cnt <= '0;
            end else if (state == ST_DRAW || fb_acc) begin
                cnt <= cnt + 5'd1;
            end

            // Accepted rows are scrubbed so the next tile starts from a clean buffer.
            if (fb_acc) begin
                color_buf[cnt[3:0]] <= '0;
                z_buf[cnt[3:0]]     <= '0;
            end else if (merge_en) begin
                for (int c = 0; c < TILE_DIM; c++) begin
                    if (wr_mask[c]) begin
                        color_buf[mrow][c] <= shifted[c];
                        z_buf[mrow][c]     <= job.z;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sm_tile_compositor.sv
// Self-checking bench: transaction-level tile model, vector table, random rounds, stall/overflow/reset.
module tb_sm_tile_compositor;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_calc_ena = 1'b0;
    logic [3:0]   i_calc_start_x = '0;
    logic [7:0]   i_calc_position_z = '0;
    logic [7:0]   i_texture_idx = '0;
    logic [5:0]   i_tile_x = '0;
    logic [5:0]   i_tile_y = '0;
    logic         i_sm_render_done = 1'b0;
    logic [11:0]  o_tex_addr;
    logic         o_tex_re;
    logic [127:0] i_tex_data = '0;
    logic         o_fb_valid;
    logic         i_fb_ready = 1'b1;
    logic [8:0]   o_fb_line;
    logic [5:0]   o_fb_tile_x;
    logic [127:0] o_fb_data;
    logic         o_fifo_full, o_overflow, o_busy;

    sm_tile_compositor dut (
        .clk(clk), .reset_n(reset_n), .i_calc_ena(i_calc_ena), .i_calc_start_x(i_calc_start_x),
        .i_calc_position_z(i_calc_position_z), .i_texture_idx(i_texture_idx), .i_tile_x(i_tile_x),
        .i_tile_y(i_tile_y), .i_sm_render_done(i_sm_render_done), .o_tex_addr(o_tex_addr),
        .o_tex_re(o_tex_re), .i_tex_data(i_tex_data), .o_fb_valid(o_fb_valid), .i_fb_ready(i_fb_ready),
        .o_fb_line(o_fb_line), .o_fb_tile_x(o_fb_tile_x), .o_fb_data(o_fb_data),
        .o_fifo_full(o_fifo_full), .o_overflow(o_overflow), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    logic [127:0] tex_mem [256][16];
    always @(posedge clk)
        i_tex_data <= o_tex_re ? tex_mem[o_tex_addr[11:4]][o_tex_addr[3:0]] : 128'h0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] data;
        logic [8:0]   line;
        logic [5:0]   tx;
    } row_t;
    row_t expq[$];

    logic [7:0]   mcol [16][16];
    logic [7:0]   mz   [16][16];
    logic [127:0] captured [16];

    typedef struct {
        logic [7:0] bg_z;
        logic [7:0] sp_z;
        logic [3:0] sx;
        logic [7:0] sp_tex;
        bit         only0;
        int         probe;
        logic [7:0] exp_color;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                mcol[r][c] = 8'h00;
                mz[r][c]   = 8'h00;
            end
    endtask

    task automatic model_draw(input logic [7:0] tex, input logic [7:0] z, input logic [3:0] sx);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                int src;
                logic [7:0] t;
                src = c - int'(sx);
                if (src >= 0) begin
                    t = tex_mem[tex][r][src*8 +: 8];
                    if (t != 8'h00 && z >= mz[r][c]) begin
                        mcol[r][c] = t;
                        mz[r][c]   = z;
                    end
                end
            end
    endtask

    task automatic model_flush(input logic [5:0] tx, input logic [5:0] ty);
        for (int r = 0; r < 16; r++) begin
            row_t e;
            for (int c = 0; c < 16; c++) e.data[c*8 +: 8] = mcol[r][c];
            e.line = {ty, 4'(r)};
            e.tx   = tx;
            expq.push_back(e);
        end
        model_clear();
    endtask

    task automatic push_draw_raw(input logic [7:0] tex, input logic [7:0] z, input logic [3:0] sx);
        i_calc_ena = 1'b1; i_texture_idx = tex; i_calc_position_z = z; i_calc_start_x = sx;
        tick();
        i_calc_ena = 1'b0;
    endtask

    task automatic push_draw(input logic [7:0] tex, input logic [7:0] z, input logic [3:0] sx);
        model_draw(tex, z, sx);
        push_draw_raw(tex, z, sx);
    endtask

    task automatic push_flush_raw(input logic [5:0] tx, input logic [5:0] ty);
        i_tile_x = tx; i_tile_y = ty; i_sm_render_done = 1'b1;
        tick();
        i_sm_render_done = 1'b0;
        tick();
    endtask

    task automatic push_flush(input logic [5:0] tx, input logic [5:0] ty);
        model_flush(tx, ty);
        push_flush_raw(tx, ty);
    endtask

    // Draw and flush pushed in the same cycle: the draw lands ahead of the flush.
    task automatic push_both(input logic [7:0] tex, input logic [7:0] z, input logic [3:0] sx,
                             input logic [5:0] tx, input logic [5:0] ty);
        model_draw(tex, z, sx);
        model_flush(tx, ty);
        i_calc_ena = 1'b1; i_texture_idx = tex; i_calc_position_z = z; i_calc_start_x = sx;
        i_tile_x = tx; i_tile_y = ty; i_sm_render_done = 1'b1;
        tick();
        i_calc_ena = 1'b0; i_sm_render_done = 1'b0;
        tick();
    endtask

    task automatic collect(input int stall_row, input int stall_n, input bit rnd);
        int acc, stalled, cyc;
        logic [127:0] hd;
        logic [8:0]   hl;
        acc = 0; stalled = 0; cyc = 0; hd = '0; hl = '0;
        while (acc < 16 && cyc < 3000) begin
            if (o_fb_valid && int'(o_fb_line[3:0]) == stall_row && stalled < stall_n) begin
                i_fb_ready = 1'b0;
                if (stalled == 0) begin
                    hd = o_fb_data; hl = o_fb_line;
                end else begin
                    check("stall_data", o_fb_data, hd);
                    check("stall_line", 128'(o_fb_line), 128'(hl));
                end
                stalled++;
            end else begin
                i_fb_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            @(negedge clk);
            if (o_fb_valid && i_fb_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_row", 128'(o_fb_line), 128'h1ff);
                end else begin
                    row_t e;
                    e = expq.pop_front();
                    check("fb_data", o_fb_data, e.data);
                    check("fb_line", 128'(o_fb_line), 128'(e.line));
                    check("fb_tile_x", 128'(o_fb_tile_x), 128'(e.tx));
                end
                captured[o_fb_line[3:0]] = o_fb_data;
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_fb_ready = 1'b1;
        if (acc < 16) check("flush_timeout", 128'(acc), 128'd16);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (o_busy && cyc < 500) begin
            tick();
            cyc++;
        end
        check("idle", 128'(o_busy), 128'd0);
    endtask

    initial begin
        for (int t = 0; t < 256; t++)
            for (int r = 0; r < 16; r++) tex_mem[t][r] = 128'h0;
        model_clear();

        // Reset state
        #12;
        check("rst_tex_re", 128'(o_tex_re), 128'd0);
        check("rst_tex_addr", 128'(o_tex_addr), 128'd0);
        check("rst_fb_valid", 128'(o_fb_valid), 128'd0);
        check("rst_fb_data", o_fb_data, 128'd0);
        check("rst_fifo_full", 128'(o_fifo_full), 128'd0);
        check("rst_overflow", 128'(o_overflow), 128'd0);
        check("rst_busy", 128'(o_busy), 128'd0);
        @(negedge clk); reset_n = 1'b1;
        tick();

        // Plain background fill
        for (int r = 0; r < 16; r++) tex_mem[3][r] = {16{8'h11}};
        push_draw(8'd3, 8'd0, 4'd0);
        push_flush(6'd0, 6'd0);
        collect(99, 0, 1'b0);
        wait_idle();
        check("bg_row0", captured[0], {16{8'h11}});
        check("bg_row15", captured[15], {16{8'h11}});

        // Background + sprite vectors
        vecs.push_back('{8'd0, 8'd5, 4'd0, 8'h22, 1'b1, 0, 8'h22});
        vecs.push_back('{8'd0, 8'd5, 4'd0, 8'h22, 1'b1, 1, 8'h11});
        vecs.push_back('{8'd0, 8'd5, 4'd5, 8'hAA, 1'b0, 4, 8'h11});
        vecs.push_back('{8'd0, 8'd5, 4'd5, 8'hAA, 1'b0, 5, 8'hAA});
        vecs.push_back('{8'd0, 8'd5, 4'd15, 8'hAA, 1'b0, 15, 8'hAA});
        vecs.push_back('{8'd0, 8'd5, 4'd0, 8'h00, 1'b0, 3, 8'h11});
        vecs.push_back('{8'd9, 8'd4, 4'd0, 8'hAA, 1'b0, 0, 8'h11});
        vecs.push_back('{8'd4, 8'd9, 4'd0, 8'hAA, 1'b0, 0, 8'hAA});
        vecs.push_back('{8'd7, 8'd7, 4'd2, 8'hAA, 1'b0, 9, 8'hAA});
        vecs.push_back('{8'd200, 8'd255, 4'd3, 8'h5C, 1'b0, 10, 8'h5C});
        foreach (vecs[i]) begin
            for (int r = 0; r < 16; r++) begin
                tex_mem[1][r] = {16{8'h11}};
                tex_mem[2][r] = vecs[i].only0 ? {120'h0, vecs[i].sp_tex} : {16{vecs[i].sp_tex}};
            end
            push_draw(8'd1, vecs[i].bg_z, 4'd0);
            push_draw(8'd2, vecs[i].sp_z, vecs[i].sx);
            push_flush(6'(i), 6'(i + 3));
            collect(99, 0, 1'b0);
            wait_idle();
            check($sformatf("vec%0d_col%0d", i, vecs[i].probe),
                  128'(captured[0][vecs[i].probe*8 +: 8]), 128'(vecs[i].exp_color));
        end

        // Stall at row 7, then an empty flush must be all zero
        for (int r = 0; r < 16; r++) tex_mem[4][r] = {$urandom, $urandom, $urandom, $urandom} | {16{8'h01}};
        push_draw(8'd4, 8'd10, 4'd0);
        push_flush(6'd5, 6'd3);
        collect(7, 3, 1'b0);
        wait_idle();
        push_flush(6'd1, 6'd1);
        collect(99, 0, 1'b0);
        wait_idle();
        check("cleared_row7", captured[7], 128'h0);

        // Random rounds against the model
        for (int rnd_i = 0; rnd_i < 6; rnd_i++) begin
            int njobs;
            for (int t = 10; t < 14; t++)
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++)
                        tex_mem[t][r][c*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            njobs = $urandom_range(1, 5);
            for (int j = 0; j < njobs; j++)
                push_draw(8'($urandom_range(10, 13)), 8'($urandom_range(0, 15)), 4'($urandom));
            if (rnd_i % 2 == 1)
                push_both(8'($urandom_range(10, 13)), 8'($urandom_range(0, 15)), 4'($urandom),
                          6'($urandom), 6'($urandom));
            else
                push_flush(6'($urandom), 6'($urandom));
            collect(99, 0, 1'b1);
            wait_idle();
        end

        // Fill the queue while a flush is stalled, then reset mid-flush
        push_draw(8'd3, 8'd3, 4'd0);
        i_fb_ready = 1'b0;
        push_flush_raw(6'd2, 6'd2);
        begin
            int cyc;
            cyc = 0;
            while (!o_fb_valid && cyc < 200) begin tick(); cyc++; end
            check("flush_started", 128'(o_fb_valid), 128'd1);
        end
        for (int j = 0; j < 8; j++) push_draw_raw(8'd3, 8'd1, 4'd0);
        check("full_at_8", 128'(o_fifo_full), 128'd1);
        check("no_ovf_at_8", 128'(o_overflow), 128'd0);
        push_draw_raw(8'd3, 8'd1, 4'd0);
        check("ovf_at_9", 128'(o_overflow), 128'd1);
        check("still_full", 128'(o_fifo_full), 128'd1);
        check("stalled_row0", o_fb_data, {16{8'h11}});
        reset_n = 1'b0;
        #1;
        check("rstmid_fb_valid", 128'(o_fb_valid), 128'd0);
        check("rstmid_fb_data", o_fb_data, 128'd0);
        check("rstmid_fifo_full", 128'(o_fifo_full), 128'd0);
        check("rstmid_overflow", 128'(o_overflow), 128'd0);
        check("rstmid_busy", 128'(o_busy), 128'd0);
        check("rstmid_tex_re", 128'(o_tex_re), 128'd0);
        model_clear();
        i_fb_ready = 1'b1;
        @(negedge clk); reset_n = 1'b1;
        tick();
        push_flush(6'd7, 6'd7);
        collect(99, 0, 1'b0);
        wait_idle();
        check("post_reset_row0", captured[0], 128'h0);
        check("expq_drained", 128'(expq.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
